sobel_engine: RTL and testbench



---
 rtl/sobel_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sobel_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_engine.sv
// rtl/sobel_engine.sv - 3x3 Sobel edge engine over a three-row line-buffer cache; optional macro SOBEL_THRESHOLD_EN
module sobel_engine #(
    parameter int WIDTH        = 352,
    parameter int HEIGHT       = 288,
    parameter int READ_LATENCY = 2,
    parameter int THRESHOLD    = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic        cache_en,
    output logic        cache_we,
    output logic [31:0] cache_di,
    output logic        cache_finish,
    input  logic        row_cached,
    input  logic [31:0] doa,
    input  logic [31:0] dob,
    input  logic [31:0] doc
);

    localparam int ROW_WIDTH = WIDTH / 4;
    localparam int KW        = $clog2(ROW_WIDTH);
    localparam int RWD       = $clog2(HEIGHT + 1);
    localparam int LW        = $clog2(READ_LATENCY);

    localparam logic [KW-1:0]  K_LAST  = KW'(ROW_WIDTH - 1);
    localparam logic [KW-1:0]  K_ONE   = KW'(1);
    localparam logic [RWD-1:0] R_TWO   = RWD'(2);
    localparam logic [RWD-1:0] R_END   = RWD'(HEIGHT);
    localparam logic [LW-1:0]  WT_LAST = LW'(READ_LATENCY - 2);

    if (WIDTH % 4 != 0 || WIDTH < 8 || HEIGHT < 3 || READ_LATENCY < 2 ||
        THRESHOLD < 0 || THRESHOLD > 256) begin : g_bad_param
        $error("sobel_engine: illegal parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_ZTOP, S_RD, S_WT, S_CALC, S_WR, S_FL, S_ZBOT, S_FIN
    } state_t;

    state_t state, state_nx;

    logic [KW-1:0]  z_cnt;
    logic [KW-1:0]  rd_k, cur_k;
    logic [RWD-1:0] rd_r, cur_r;
    logic [LW-1:0]  wt_cnt;
    logic [31:0]    in_a, in_b, in_c;
    logic [31:0]    a_cur, a_nxt, b_cur, b_nxt, c_cur, c_nxt;
    logic [31:0]    calc_word, flush_word;
    logic           reads_left;

    logic           en_d, we_d, fin_d, done_d;
    logic [31:0]    di_d;

    // Four output pixels from a 6-pixel span per row (left byte, centre word, right byte).
    function automatic logic [31:0] sobel_word(
        input logic [7:0]  la, input logic [31:0] ca, input logic [7:0] ra,
        input logic [7:0]  lb, input logic [31:0] cb, input logic [7:0] rb,
        input logic [7:0]  lc, input logic [31:0] cc, input logic [7:0] rc,
        input logic        zero_first,
        input logic        zero_last
    );
        logic [7:0]         a [0:5];
        logic [7:0]         b [0:5];
        logic [7:0]         c [0:5];
        logic [9:0]         s_left, s_right, s_top, s_bot;
        logic signed [10:0] gx, gy;
        logic [10:0]        ax, ay;
        logic [11:0]        mag;
        logic [7:0]         pix;
        logic [31:0]        res;
        a[0] = la; a[5] = ra;
        b[0] = lb; b[5] = rb;
        c[0] = lc; c[5] = rc;
        for (int j = 0; j < 4; j++) begin
            a[j+1] = ca[31-8*j -: 8];
            b[j+1] = cb[31-8*j -: 8];
            c[j+1] = cc[31-8*j -: 8];
        end
        res = '0;
        for (int i = 0; i < 4; i++) begin
            s_left  = {2'b00, a[i]}   + {1'b0, b[i], 1'b0}   + {2'b00, c[i]};
            s_right = {2'b00, a[i+2]} + {1'b0, b[i+2], 1'b0} + {2'b00, c[i+2]};
            s_top   = {2'b00, a[i]}   + {1'b0, a[i+1], 1'b0} + {2'b00, a[i+2]};
            s_bot   = {2'b00, c[i]}   + {1'b0, c[i+1], 1'b0} + {2'b00, c[i+2]};
            gx  = $signed({1'b0, s_right}) - $signed({1'b0, s_left});
            gy  = $signed({1'b0, s_bot})   - $signed({1'b0, s_top});
            ax  = gx[10] ? 11'(-gx) : 11'(gx);
            ay  = gy[10] ? 11'(-gy) : 11'(gy);
            mag = {1'b0, ax} + {1'b0, ay};
            pix = (mag > 12'd255) ? 8'hFF : mag[7:0];
`ifdef SOBEL_THRESHOLD_EN
            pix = ({1'b0, pix} >= 9'(THRESHOLD)) ? 8'hFF : 8'h00;
`endif
            if ((i == 0 && zero_first) || (i == 3 && zero_last)) begin
                pix = 8'h00;
            end
            res[31-8*i -: 8] = pix;
        end
        return res;
    endfunction

    // Word k-1 before the window shift, and the row-end word with a zero right neighbour after it.
    assign calc_word  = sobel_word(a_cur[7:0], a_nxt, in_a[31:24],
                                   b_cur[7:0], b_nxt, in_b[31:24],
                                   c_cur[7:0], c_nxt, in_c[31:24],
                                   cur_k == K_ONE, 1'b0);
    assign flush_word = sobel_word(a_cur[7:0], a_nxt, 8'h00,
                                   b_cur[7:0], b_nxt, 8'h00,
                                   c_cur[7:0], c_nxt, 8'h00,
                                   1'b0, 1'b1);
    assign reads_left = (rd_r != R_END);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next state plus the values the output registers take on entering it.
    always_comb begin
        state_nx = state;
        en_d     = 1'b0;
        we_d     = 1'b0;
        fin_d    = 1'b0;
        di_d     = 32'd0;
        done_d   = done;
        case (state)
            S_IDLE: if (start) begin
                state_nx = S_ZTOP;
                done_d   = 1'b0;
            end
            S_ZTOP: if (z_cnt == K_LAST) state_nx = S_RD;
            S_RD:   state_nx = S_WT;
            S_WT:   if (wt_cnt == WT_LAST) state_nx = S_CALC;
            S_CALC: begin
                if (cur_r >= R_TWO && cur_k != '0) begin
                    state_nx = S_WR;
                    di_d     = calc_word;
                end else begin
                    state_nx = S_RD;
                end
            end
            S_WR: begin
                if (cur_k == K_LAST) begin
                    state_nx = S_FL;
                    di_d     = flush_word;
                end else if (reads_left) begin
                    state_nx = S_RD;
                end else begin
                    state_nx = S_ZBOT;
                end
            end
            S_FL:   state_nx = reads_left ? S_RD : S_ZBOT;
            S_ZBOT: if (z_cnt == K_LAST) state_nx = S_FIN;
            S_FIN: begin
                state_nx = S_IDLE;
                done_d   = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
        case (state_nx)
            S_ZTOP, S_ZBOT, S_WR, S_FL: begin
                en_d = 1'b1;
                we_d = 1'b1;
            end
            S_RD:  en_d  = 1'b1;
            S_FIN: fin_d = 1'b1;
            default: ;
        endcase
    end

    // Registered cache-side and host-side outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_en     <= 1'b0;
            cache_we     <= 1'b0;
            cache_di     <= 32'd0;
            cache_finish <= 1'b0;
            done         <= 1'b0;
        end else begin
            cache_en     <= en_d;
            cache_we     <= we_d;
            cache_di     <= di_d;
            cache_finish <= fin_d;
            done         <= done_d;
        end
    end

    // Read address walk, latency wait, input sampling and 3x3-word window shift.
    always_ff @(posedge clk) begin
        if (!rst) begin
            z_cnt  <= '0;
            rd_k   <= '0;
            rd_r   <= '0;
            cur_k  <= '0;
            cur_r  <= '0;
            wt_cnt <= '0;
            in_a   <= '0;
            in_b   <= '0;
            in_c   <= '0;
            a_cur  <= '0;
            a_nxt  <= '0;
            b_cur  <= '0;
            b_nxt  <= '0;
            c_cur  <= '0;
            c_nxt  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    z_cnt <= '0;
                    rd_k  <= '0;
                    rd_r  <= '0;
                end
                S_ZTOP, S_ZBOT: z_cnt <= (z_cnt == K_LAST) ? '0 : z_cnt + K_ONE;
                S_RD: begin
                    cur_k  <= rd_k;
                    cur_r  <= rd_r;
                    wt_cnt <= '0;
                    if (rd_k == K_LAST) begin
                        rd_k <= '0;
                        rd_r <= rd_r + RWD'(1);
                    end else begin
                        rd_k <= rd_k + K_ONE;
                    end
                end
                S_WT: begin
                    if (wt_cnt == WT_LAST) begin
                        in_a <= doa;
                        in_b <= dob;
                        in_c <= doc;
                    end else begin
                        wt_cnt <= wt_cnt + LW'(1);
                    end
                end
                S_CALC: begin
                    // A new row starts with a zero left neighbour for its first word.
                    if (cur_k == '0) begin
                        a_cur <= '0;
                        b_cur <= '0;
                        c_cur <= '0;
                    end else begin
                        a_cur <= a_nxt;
                        b_cur <= b_nxt;
                        c_cur <= c_nxt;
                    end
                    a_nxt <= in_a;
                    b_nxt <= in_b;
                    c_nxt <= in_c;
                end
                default: ;
            endcase
        end
    end

    // Writes only start after two full rows were read, so the cache must report a cached row.
    assert property (@(posedge clk) disable iff (!rst) (state == S_WR) |-> row_cached);

endmodule

// File: tb/tb_sobel_engine.sv
// tb/tb_sobel_engine.sv - directed bench for sobel_engine with a behavioural line-buffer cache
module tb_sobel_engine;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int RW = W / 4;
    localparam int NW = W * H / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic        cache_en, cache_we, cache_finish;
    logic [31:0] cache_di;
    logic        row_cached = 1'b0;
    logic [31:0] doa = 32'd0, dob = 32'd0, doc = 32'd0;

    logic [31:0] img     [NW];
    logic [31:0] out_mem [NW];
    logic [31:0] exp_mem [NW];

    int   rd_ptr = 0, wr_ptr = 0, rd_total = 0, wr_total = 0;
    int   fin_cnt = 0, b2b_rd = 0, first_wr_rd = 0;
    logic prev_rd = 1'b0;
    int   n_cmp = 0, n_err = 0;

    sobel_engine #(
        .WIDTH(W), .HEIGHT(H), .READ_LATENCY(2), .THRESHOLD(128)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .cache_en(cache_en), .cache_we(cache_we), .cache_di(cache_di),
        .cache_finish(cache_finish), .row_cached(row_cached),
        .doa(doa), .dob(dob), .doc(doc)
    );

    always #5 clk = ~clk;

    // Cache model: serves reads, records writes, rewinds on finish or reset.
    always @(negedge clk) begin
        if (!rst) begin
            rd_ptr     = 0;
            wr_ptr     = 0;
            prev_rd    = 1'b0;
            row_cached = 1'b0;
        end else begin
            if (cache_en && !cache_we) begin
                if (prev_rd) b2b_rd++;
                if (rd_ptr < NW) begin
                    doc = img[rd_ptr];
                    dob = (rd_ptr >= RW)     ? img[rd_ptr-RW]   : 32'd0;
                    doa = (rd_ptr >= 2 * RW) ? img[rd_ptr-2*RW] : 32'd0;
                end
                rd_ptr++;
            end
            if (cache_en && cache_we) begin
                if (wr_ptr == RW) first_wr_rd = rd_ptr;
                if (wr_ptr < NW) out_mem[wr_ptr] = cache_di;
                wr_ptr++;
            end
            prev_rd = cache_en && !cache_we;
            if (cache_finish) begin
                fin_cnt++;
                rd_total = rd_ptr;
                wr_total = wr_ptr;
                rd_ptr   = 0;
                wr_ptr   = 0;
            end
            row_cached = (rd_ptr >= RW);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int r, input int c, input logic [7:0] v);
        img[r*RW + c/4][31-8*(c%4) -: 8] = v;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < NW; i++) exp_mem[i] = 32'd0;
    endtask

    task automatic set_exp(input int r, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        exp_mem[r*RW+0] = w0;
        exp_mem[r*RW+1] = w1;
        exp_mem[r*RW+2] = w2;
        exp_mem[r*RW+3] = w3;
    endtask

    task automatic run_frame(input string name, input bit poke);
        int fin_base, b2b_base, pk;
        bit got;
        fin_base = fin_cnt;
        b2b_base = b2b_rd;
        pk  = 0;
        got = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({name, ".done_clr"}, 32'(done), 32'd0);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (poke && rd_ptr >= 12 && pk < 4) begin
                start = 1'b1;
                pk++;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({name, ".done"},    32'(got), 32'd1);
        check({name, ".reads"},   32'(rd_total), 32'(NW));
        check({name, ".writes"},  32'(wr_total), 32'(NW));
        check({name, ".finish"},  32'(fin_cnt - fin_base), 32'd1);
        check({name, ".b2b_rd"},  32'(b2b_rd - b2b_base), 32'd0);
        check({name, ".first_wr"}, 32'(first_wr_rd), 32'd10);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("%s.word%0d", name, i), out_mem[i], exp_mem[i]);
        end
    endtask

    initial begin
        int  fin_base, en_seen;
        bit  hit;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.cache_en", 32'(cache_en), 32'd0);
        check("rst.cache_we", 32'(cache_we), 32'd0);
        check("rst.cache_di", cache_di, 32'd0);
        check("rst.finish",   32'(cache_finish), 32'd0);
        check("rst.done",     32'(done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NW; i++) img[i] = 32'h80808080;
        clear_exp();
        run_frame("uniform", 1'b0);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) set_pix(r, c, (c >= 8) ? 8'hFF : 8'h00);
        clear_exp();
        for (int r = 1; r <= 6; r++) set_exp(r, 32'h0, 32'h000000FF, 32'hFF000000, 32'h0);
        run_frame("vstep", 1'b0);
        run_frame("vstep_poke", 1'b1);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) set_pix(r, c, (r >= 4) ? 8'd200 : 8'd0);
        clear_exp();
        set_exp(3, 32'h00FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFF00);
        set_exp(4, 32'h00FFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFF00);
        run_frame("hstep", 1'b0);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) set_pix(r, c, 8'(8 * c));
        clear_exp();
`ifndef SOBEL_THRESHOLD_EN
        for (int r = 1; r <= 6; r++) set_exp(r, 32'h00404040, 32'h40404040, 32'h40404040, 32'h40404000);
`endif
        run_frame("ramp", 1'b0);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) set_pix(r, c, (r >= 4) ? 8'd200 : 8'd0);
        fin_base = fin_cnt;
        hit = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            #1;
            if (cache_en && cache_we && wr_ptr == 13) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort.reached_wr", 32'(hit), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort.cache_en", 32'(cache_en), 32'd0);
        check("abort.cache_we", 32'(cache_we), 32'd0);
        check("abort.cache_di", cache_di, 32'd0);
        check("abort.finish",   32'(cache_finish), 32'd0);
        check("abort.done",     32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        en_seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cache_en || cache_finish) en_seen++;
        end
        check("abort.idle_quiet", 32'(en_seen), 32'd0);
        check("abort.no_finish",  32'(fin_cnt - fin_base), 32'd0);

        for (int i = 0; i < NW; i++) img[i] = 32'h80808080;
        clear_exp();
        run_frame("recover", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
